// File: rtl/int_sched_pkg.sv
// rtl/int_sched_pkg.sv - shared types, cause codes and priority order for int_sched
//   Contents: int_sched_state_t state enum, CAUSE_* interrupt cause codes,
//   PRIO_ORDER highest-first list, CAUSE_MASK of schedulable bits,
//   pickCause() helper returning the highest-priority set bit of a 12-bit set.
package int_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ISSUE = 2'd2,
        WFI   = 2'd3
    } int_sched_state_t;

    localparam logic [3:0] CAUSE_SSI = 4'd1;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_STI = 4'd5;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_SEI = 4'd9;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int PRIO_LEN = 6;

    // Highest priority first.
    localparam logic [3:0] PRIO_ORDER [PRIO_LEN] = '{
        CAUSE_MEI, CAUSE_MSI, CAUSE_MTI, CAUSE_SEI, CAUSE_SSI, CAUSE_STI
    };

    // Only the six architected causes can be scheduled; other bits have no cause code.
    localparam logic [11:0] CAUSE_MASK = 12'hAAA;

    // Walk the list lowest priority first so the highest-priority hit is written last.
    function automatic logic [3:0] pickCause(input logic [11:0] set);
        logic [3:0] c;
        c = 4'd0;
        for (int i = PRIO_LEN - 1; i >= 0; i--) begin
            if (set[PRIO_ORDER[i]]) begin
                c = PRIO_ORDER[i];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - combinational priority encoder over qualified M and S interrupt sets
//   mSet  in  12  enabled, non-delegated pending interrupts
//   sSet  in  12  enabled, delegated pending interrupts
//   valid out 1   some schedulable interrupt present
//   cause out 4   winning cause code
//   deleg out 1   winner came from the S set
module int_prio_enc
    import int_sched_pkg::*;
(
    input  logic [11:0] mSet,
    input  logic [11:0] sSet,
    output logic        valid,
    output logic [3:0]  cause,
    output logic        deleg
);

    logic [11:0] mQual;
    logic [11:0] sQual;

    assign mQual = mSet & CAUSE_MASK;
    assign sQual = sSet & CAUSE_MASK;

    // Any M-level interrupt outranks every S-level one, regardless of cause.
    always_comb begin
        valid = 1'b0;
        cause = 4'd0;
        deleg = 1'b0;
        if (|mQual) begin
            valid = 1'b1;
            cause = pickCause(mQual);
        end else if (|sQual) begin
            valid = 1'b1;
            cause = pickCause(sQual);
            deleg = 1'b1;
        end
    end

endmodule

// File: rtl/int_sched.sv
// rtl/int_sched.sv - interrupt scheduler and WFI sequencer between CSR file and trap unit
//   Optional macro INT_SCHED_WFI_TIMEOUT_EN: enables the WFI cycle counter so the
//   TW timeout fires after TW_TIMEOUT stall cycles; without it the timeout is immediate.
//   Inputs : clk, reset (sync, active-high), MIP_REGW/MIE_REGW/MIDELEG_REGW [11:0],
//            STATUS_MIE, STATUS_SIE, STATUS_TW, PrivilegeModeW [1:0],
//            CommittedM, CommittedF, InstrValidM, wfiM, TrapAckM
//   Outputs: IntReqM, IntCauseM [3:0], IntDelegateM, IntPendingM, WfiStallM, WfiTimeoutM
module int_sched
    import int_sched_pkg::*;
#(
    parameter int TW_TIMEOUT = 255,
    parameter int TCNT_BITS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] MIP_REGW,
    input  logic [11:0] MIE_REGW,
    input  logic [11:0] MIDELEG_REGW,
    input  logic        STATUS_MIE,
    input  logic        STATUS_SIE,
    input  logic        STATUS_TW,
    input  logic [1:0]  PrivilegeModeW,
    input  logic        CommittedM,
    input  logic        CommittedF,
    input  logic        InstrValidM,
    input  logic        wfiM,
    input  logic        TrapAckM,
    output logic        IntReqM,
    output logic [3:0]  IntCauseM,
    output logic        IntDelegateM,
    output logic        IntPendingM,
    output logic        WfiStallM,
    output logic        WfiTimeoutM
);

    if (TW_TIMEOUT >= (1 << TCNT_BITS)) begin : gBadParam
        $error("int_sched: TCNT_BITS too narrow for TW_TIMEOUT");
    end

    int_sched_state_t state;

    logic [11:0] pend;
    logic [11:0] mSet;
    logic [11:0] sSet;
    logic        mEnable;
    logic        sEnable;
    logic        candValid;
    logic [3:0]  candCause;
    logic        candDeleg;
    logic [3:0]  causeReg;
    logic        delegReg;
    logic        pendReg;
    logic        cntAtLimit;
    logic        wfiTimeout;

    assign pend    = MIP_REGW & MIE_REGW;
    assign mEnable = (PrivilegeModeW != 2'd3) | STATUS_MIE;
    // S-level interrupts are masked entirely while in M-mode.
    assign sEnable = (PrivilegeModeW == 2'd0) | ((PrivilegeModeW == 2'd1) & STATUS_SIE);
    assign mSet    = mEnable ? (pend & ~MIDELEG_REGW) : 12'd0;
    assign sSet    = sEnable ? (pend & MIDELEG_REGW) : 12'd0;

    int_prio_enc uPrioEnc (
        .mSet  (mSet),
        .sSet  (sSet),
        .valid (candValid),
        .cause (candCause),
        .deleg (candDeleg)
    );

`ifdef INT_SCHED_WFI_TIMEOUT_EN
    logic [TCNT_BITS-1:0] wfiCnt;

    // Counter only runs inside WFI, so leaving WFI doubles as the clear on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wfiCnt <= '0;
        end else if (state != WFI) begin
            wfiCnt <= '0;
        end else if (wfiCnt != {TCNT_BITS{1'b1}}) begin
            wfiCnt <= wfiCnt + 1'b1;
        end
    end

    assign cntAtLimit = (wfiCnt == TCNT_BITS'(TW_TIMEOUT));
`else
    assign cntAtLimit = 1'b1;
`endif

    // Any ungated pending bit wakes WFI, and a wake-up suppresses the timeout.
    assign wfiTimeout = (state == WFI) & ~reset & ~(|pend) & STATUS_TW &
                        (PrivilegeModeW != 2'd3) & cntAtLimit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            causeReg <= 4'd0;
            delegReg <= 1'b0;
            pendReg  <= 1'b0;
        end else begin
            pendReg <= |pend;
            case (state)
                IDLE: begin
                    if (candValid) begin
                        state <= ARMED;
                    end else if (wfiM & InstrValidM) begin
                        state <= WFI;
                    end
                end
                ARMED: begin
                    // Track the current winner until issue; ISSUE then freezes it.
                    causeReg <= candCause;
                    delegReg <= candDeleg;
                    if (!candValid) begin
                        state <= IDLE;
                    end else if (!CommittedM && !CommittedF) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (TrapAckM || !candValid) begin
                        state <= IDLE;
                    end
                end
                WFI: begin
                    if (|pend) begin
                        state <= candValid ? ARMED : IDLE;
                    end else if (wfiTimeout) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IntReqM      = (state == ISSUE);
    assign IntCauseM    = causeReg;
    assign IntDelegateM = delegReg;
    assign IntPendingM  = pendReg;
    assign WfiStallM    = (state == WFI);
    assign WfiTimeoutM  = wfiTimeout;

endmodule

// File: tb/tb_int_sched.sv
// tb/tb_int_sched.sv - self-checking bench for int_sched with directed and random stimulus
module tb_int_sched;

`ifdef INT_SCHED_WFI_TIMEOUT_EN
    localparam int TO = 255;
`else
    localparam int TO = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] MIP_REGW, MIE_REGW, MIDELEG_REGW;
    logic        STATUS_MIE, STATUS_SIE, STATUS_TW;
    logic [1:0]  PrivilegeModeW;
    logic        CommittedM, CommittedF, InstrValidM, wfiM, TrapAckM;
    logic        IntReqM, IntDelegateM, IntPendingM, WfiStallM, WfiTimeoutM;
    logic [3:0]  IntCauseM;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the scheduler is doing, in plain terms.
    bit mArmed, mIssue, mWfi, mPend, mDeleg;
    int mCause, mCnt;
    bit sTo, sStall;
    int prio[6] = '{11, 3, 7, 9, 1, 5};

    int_sched dut (
        .clk(clk), .reset(reset),
        .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW), .MIDELEG_REGW(MIDELEG_REGW),
        .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_TW(STATUS_TW),
        .PrivilegeModeW(PrivilegeModeW),
        .CommittedM(CommittedM), .CommittedF(CommittedF), .InstrValidM(InstrValidM),
        .wfiM(wfiM), .TrapAckM(TrapAckM),
        .IntReqM(IntReqM), .IntCauseM(IntCauseM), .IntDelegateM(IntDelegateM),
        .IntPendingM(IntPendingM), .WfiStallM(WfiStallM), .WfiTimeoutM(WfiTimeoutM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner by the architectural rules: M-level first, then S-level, each in list order.
    task automatic getCand(output bit v, output int c, output bit d);
        bit [11:0] p;
        bit mOk, sOk;
        p   = MIP_REGW & MIE_REGW;
        mOk = (PrivilegeModeW < 3) || STATUS_MIE;
        sOk = (PrivilegeModeW == 0) || (PrivilegeModeW == 1 && STATUS_SIE);
        v = 0; c = 0; d = 0;
        foreach (prio[i]) begin
            if (!v && mOk && p[prio[i]] && !MIDELEG_REGW[prio[i]]) begin
                v = 1; c = prio[i];
            end
        end
        foreach (prio[i]) begin
            if (!v && sOk && p[prio[i]] && MIDELEG_REGW[prio[i]]) begin
                v = 1; c = prio[i]; d = 1;
            end
        end
    endtask

    // One cycle: compare at mid-cycle, advance the model, return just after the rising edge.
    task automatic tick();
        bit cv, cd, expTo;
        int cc;
        bit [11:0] p;
        @(negedge clk);
        #1;
        p = MIP_REGW & MIE_REGW;
        getCand(cv, cc, cd);
        expTo = mWfi && !reset && p == 0 && STATUS_TW && PrivilegeModeW != 3 && mCnt == TO;
        chk("req", IntReqM, mIssue);
        chk("stall", WfiStallM, mWfi);
        chk("timeout", WfiTimeoutM, expTo);
        chk("pending", IntPendingM, mPend);
        if (mIssue) begin
            chk("cause", IntCauseM, mCause);
            chk("deleg", IntDelegateM, mDeleg);
        end
        sTo = WfiTimeoutM;
        sStall = WfiStallM;
        if (reset) begin
            mArmed = 0; mIssue = 0; mWfi = 0; mPend = 0; mCause = 0; mDeleg = 0; mCnt = 0;
        end else begin
            mPend = (p != 0);
            if (mIssue) begin
                if (TrapAckM || !cv) mIssue = 0;
            end else if (mArmed) begin
                mCause = cc; mDeleg = cd;
                if (!cv) mArmed = 0;
                else if (!CommittedM && !CommittedF) begin mArmed = 0; mIssue = 1; end
            end else if (mWfi) begin
                if (p != 0) begin mWfi = 0; mArmed = cv; end
                else if (expTo) mWfi = 0;
`ifdef INT_SCHED_WFI_TIMEOUT_EN
                else if (mCnt < 255) mCnt++;
`endif
            end else if (cv) begin
                mArmed = 1;
            end else if (wfiM && InstrValidM) begin
                mWfi = 1; mCnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        MIP_REGW = 0; MIE_REGW = 0; MIDELEG_REGW = 0;
        STATUS_MIE = 0; STATUS_SIE = 0; STATUS_TW = 0; PrivilegeModeW = 0;
        CommittedM = 0; CommittedF = 0; InstrValidM = 0; wfiM = 0; TrapAckM = 0;
    endtask

    initial begin
        int pulses, stallBefore, at, t;
        reset = 1;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", IntReqM, 0);
        chk("rst_cause", IntCauseM, 0);
        chk("rst_deleg", IntDelegateM, 0);
        chk("rst_pend", IntPendingM, 0);
        chk("rst_stall", WfiStallM, 0);
        chk("rst_tmo", WfiTimeoutM, 0);
        reset = 0;

        // MTI in U-mode: request two cycles after pending, dropped after ack.
        MIP_REGW = 12'h080; MIE_REGW = 12'h080;
        tick(); tick();
        chk("t1_req", IntReqM, 1);
        chk("t1_cause", IntCauseM, 7);
        chk("t1_deleg", IntDelegateM, 0);
        TrapAckM = 1; MIP_REGW = 0;
        tick();
        chk("t1_ack", IntReqM, 0);
        quiet(); tick();

        // Delegated SSI/STI/SEI in S-mode: SEI wins and is delegated.
        MIP_REGW = 12'h222; MIE_REGW = 12'h222; MIDELEG_REGW = 12'h222;
        PrivilegeModeW = 1; STATUS_SIE = 1;
        tick(); tick();
        chk("t2_req", IntReqM, 1);
        chk("t2_cause", IntCauseM, 9);
        chk("t2_deleg", IntDelegateM, 1);
        TrapAckM = 1; PrivilegeModeW = 3;
        tick();
        TrapAckM = 0;
        repeat (4) tick();
        chk("t2_mmode", IntReqM, 0);
        quiet(); tick();

        // MEI held off by a committed access.
        MIP_REGW = 12'h800; MIE_REGW = 12'h800; PrivilegeModeW = 3; STATUS_MIE = 1;
        CommittedM = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold", IntReqM, 0);
        end
        CommittedM = 0;
        tick();
        chk("t3_go", IntReqM, 1);
        chk("t3_cause", IntCauseM, 11);
        TrapAckM = 1; MIP_REGW = 0;
        tick();
        quiet(); tick();

        // WFI timeout in U-mode with TW set.
        STATUS_TW = 1; wfiM = 1; InstrValidM = 1;
        tick();
        wfiM = 0;
        pulses = 0; stallBefore = 0; at = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (sTo) begin
                pulses++;
                if (pulses == 1) at = stallBefore;
            end else if (sStall) begin
                stallBefore++;
            end else if (pulses > 0) begin
                break;
            end
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_delay", at, TO);
        quiet(); tick();

        // WFI in M-mode woken by MSI with MIE clear: exits, no request, no timeout.
        STATUS_TW = 1; PrivilegeModeW = 3; wfiM = 1; InstrValidM = 1;
        tick();
        wfiM = 0;
        repeat (10) tick();
        MIP_REGW = 12'h008; MIE_REGW = 12'h008;
        tick();
        chk("t5_stall", WfiStallM, 0);
        chk("t5_pend", IntPendingM, 1);
        chk("t5_req", IntReqM, 0);
        repeat (3) tick();
        chk("t5_noreq", IntReqM, 0);
        quiet(); tick();

        // Reset during ISSUE, then re-arm with the interrupt still pending.
        MIP_REGW = 12'h080; MIE_REGW = 12'h080;
        tick(); tick();
        chk("t6_issue", IntReqM, 1);
        reset = 1;
        tick();
        chk("t6_rst", IntReqM, 0);
        reset = 0;
        tick(); tick();
        chk("t6_rearm", IntReqM, 1);
        TrapAckM = 1; MIP_REGW = 0;
        tick();
        quiet(); tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(99) == 0);
            MIP_REGW = ($urandom_range(9) < 4) ? 12'($urandom) & 12'hAAA : 12'h000;
            MIE_REGW = 12'($urandom) | 12'($urandom);
            MIDELEG_REGW = 12'($urandom);
            STATUS_MIE = 1'($urandom);
            STATUS_SIE = 1'($urandom);
            STATUS_TW = 1'($urandom);
            t = $urandom_range(2);
            PrivilegeModeW = (t == 2) ? 2'd3 : 2'(t);
            CommittedM = ($urandom_range(9) < 3);
            CommittedF = ($urandom_range(9) < 3);
            InstrValidM = ($urandom_range(9) < 8);
            wfiM = ($urandom_range(9) < 2);
            TrapAckM = ($urandom_range(9) < 3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
